// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller and its multiply/divide timer.
package pipe_stall_ctrl_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;
   localparam int unsigned CNT_W           = 4;

   // Pick the busy latency for an issuing mult/div instruction.
   function automatic logic [CNT_W-1:0] md_latency(input logic is_div,
                                                   input logic [CNT_W-1:0] mult_cyc,
                                                   input logic [CNT_W-1:0] div_cyc);
      return is_div ? div_cyc : mult_cyc;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_md_timer.sv
// Multiply/divide occupancy timer: loads a latency, counts it down while BUSY,
// and pulses done for one cycle after returning to IDLE.
module md_timer
   import pipe_stall_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             busy,
   output logic             done
);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             done_reg, done_next;

   // load is only honoured from IDLE; a request while BUSY is the caller's error to flag.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (load) begin
               cnt_next   = load_val;
               state_next = BUSY;
            end
         end
         BUSY: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
      end
   end

   assign busy = (state_reg == BUSY);
   assign done = done_reg;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: combines load-use and mult/div hazards into PC/FD
// enables and a D/E flush, tracks mult/div occupancy and counts stalled cycles.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        e_md_start,
   input  logic        e_md_is_div,
   input  logic        d_md_use,
   input  logic        d_load_use,
   output logic        md_busy,
   output logic        md_done,
   output logic        pc_en,
   output logic        fd_en,
   output logic        de_flush,
   output logic        md_err,
   output logic [31:0] stall_cnt
);

   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   logic             stall;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             md_err_reg, md_err_next;
   logic [31:0]      stall_cnt_reg, stall_cnt_next;

   // A start that lands while busy (including the final busy cycle) never reloads.
   assign timer_load = e_md_start & ~md_busy;
   assign timer_val  = md_latency(e_md_is_div, MULT_LD, DIV_LD);

   md_timer u_md_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .busy     (md_busy),
      .done     (md_done)
   );

   // The issuing cycle counts as a hazard so the dependent D-stage op waits too.
   assign stall    = d_load_use | (d_md_use & (md_busy | e_md_start));
   assign pc_en    = ~stall;
   assign fd_en    = ~stall;
   assign de_flush = stall;

   always_comb begin
      md_err_next    = md_err_reg | (e_md_start & md_busy);
      stall_cnt_next = stall_cnt_reg;
      if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
         stall_cnt_next = stall_cnt_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_err_reg    <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         md_err_reg    <= md_err_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign md_err    = md_err_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl with default latencies (5/10).
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_md_start;
   logic        e_md_is_div;
   logic        d_md_use;
   logic        d_load_use;
   logic        md_busy;
   logic        md_done;
   logic        pc_en;
   logic        fd_en;
   logic        de_flush;
   logic        md_err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stall_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .e_md_start  (e_md_start),
      .e_md_is_div (e_md_is_div),
      .d_md_use    (d_md_use),
      .d_load_use  (d_load_use),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .pc_en       (pc_en),
      .fd_en       (fd_en),
      .de_flush    (de_flush),
      .md_err      (md_err),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 2 ns later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      e_md_start  = 1'b0;
      e_md_is_div = 1'b0;
      d_md_use    = 1'b0;
      d_load_use  = 1'b0;
      reset       = 1'b1;
      tick();
      reset       = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      do_reset();
      $display("txn reset: busy=%0b done=%0b err=%0b cnt=%0d", md_busy, md_done, md_err, stall_cnt);
      check("rst_busy", 32'(md_busy), 32'd0);
      check("rst_done", 32'(md_done), 32'd0);
      check("rst_err",  32'(md_err),  32'd0);
      check("rst_cnt",  stall_cnt,    32'd0);
      check("rst_pcen", 32'(pc_en),   32'd1);

      // Mult latency: busy 5 cycles, done in cycle 6
      e_md_start = 1'b1; e_md_is_div = 1'b0; #1;
      check("mul_busy_pre", 32'(md_busy), 32'd0);
      tick(); e_md_start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("mul_busy_%0d", i), 32'(md_busy), 32'd1);
         check($sformatf("mul_done_%0d", i), 32'(md_done), 32'd0);
         tick();
      end
      check("mul_busy_end", 32'(md_busy), 32'd0);
      check("mul_done_end", 32'(md_done), 32'd1);
      check("mul_err",      32'(md_err),  32'd0);
      tick();
      check("mul_done_off", 32'(md_done), 32'd0);
      $display("txn mult: done pulse seen, err=%0b", md_err);

      // Div with dependent D-stage op: start cycle + 10 busy cycles stalled
      do_reset();
      e_md_start = 1'b1; e_md_is_div = 1'b1; d_md_use = 1'b1; #1;
      check("div_pcen_start",  32'(pc_en),    32'd0);
      check("div_fden_start",  32'(fd_en),    32'd0);
      check("div_flush_start", 32'(de_flush), 32'd1);
      tick(); e_md_start = 1'b0; e_md_is_div = 1'b0; #1;
      for (int i = 1; i <= 10; i++) begin
         check($sformatf("div_busy_%0d", i),  32'(md_busy),  32'd1);
         check($sformatf("div_pcen_%0d", i),  32'(pc_en),    32'd0);
         check($sformatf("div_flush_%0d", i), 32'(de_flush), 32'd1);
         tick();
      end
      check("div_busy_end", 32'(md_busy), 32'd0);
      check("div_done_end", 32'(md_done), 32'd1);
      check("div_pcen_end", 32'(pc_en),   32'd1);
      check("div_cnt",      stall_cnt,    32'd11);
      d_md_use = 1'b0;
      $display("txn div: stall_cnt=%0d", stall_cnt);

      // Load-use while idle: exactly one stalled cycle
      do_reset();
      d_load_use = 1'b1; #1;
      check("lu_pcen",  32'(pc_en),    32'd0);
      check("lu_fden",  32'(fd_en),    32'd0);
      check("lu_flush", 32'(de_flush), 32'd1);
      tick(); d_load_use = 1'b0; #1;
      check("lu_cnt",   stall_cnt,     32'd1);
      check("lu_busy",  32'(md_busy),  32'd0);
      check("lu_pcen2", 32'(pc_en),    32'd1);
      tick();
      check("lu_cnt2",  stall_cnt,     32'd1);
      $display("txn load_use: stall_cnt=%0d", stall_cnt);

      // Illegal restart in 3rd busy cycle of a mult (div flavour must not reload)
      do_reset();
      e_md_start = 1'b1; e_md_is_div = 1'b0;
      tick(); e_md_start = 1'b0;
      tick();
      tick();
      e_md_start = 1'b1; e_md_is_div = 1'b1;
      tick(); e_md_start = 1'b0; e_md_is_div = 1'b0;
      check("rs_err_4",  32'(md_err),  32'd1);
      check("rs_busy_4", 32'(md_busy), 32'd1);
      tick();
      check("rs_busy_5", 32'(md_busy), 32'd1);
      tick();
      check("rs_busy_6", 32'(md_busy), 32'd0);
      check("rs_done_6", 32'(md_done), 32'd1);
      tick();
      check("rs_err_7",  32'(md_err),  32'd1);
      check("rs_busy_7", 32'(md_busy), 32'd0);
      $display("txn restart: err=%0b", md_err);

      // Start coinciding with the final busy cycle is an error, not a reissue
      do_reset();
      e_md_start = 1'b1; e_md_is_div = 1'b0;
      tick(); e_md_start = 1'b0;
      tick(); tick(); tick(); tick();
      check("edge_busy_last", 32'(md_busy), 32'd1);
      e_md_start = 1'b1;
      tick(); e_md_start = 1'b0;
      check("edge_busy", 32'(md_busy), 32'd0);
      check("edge_done", 32'(md_done), 32'd1);
      check("edge_err",  32'(md_err),  32'd1);
      tick();
      check("edge_busy2", 32'(md_busy), 32'd0);
      $display("txn edge_start: err=%0b busy=%0b", md_err, md_busy);

      // Asynchronous reset in the middle of a div
      do_reset();
      e_md_start = 1'b1; e_md_is_div = 1'b1; d_md_use = 1'b1;
      tick(); e_md_start = 1'b0; e_md_is_div = 1'b0;
      tick(); tick(); tick();
      check("mr_cnt_pre", stall_cnt, 32'd4);
      #1 reset = 1'b1; #1;
      check("mr_busy", 32'(md_busy), 32'd0);
      check("mr_cnt",  stall_cnt,    32'd0);
      check("mr_done", 32'(md_done), 32'd0);
      check("mr_pcen", 32'(pc_en),   32'd1);
      d_load_use = 1'b1; #1;
      check("mr_pcen_lu", 32'(pc_en), 32'd0);
      tick();
      check("mr_cnt_held", stall_cnt, 32'd0);
      d_load_use = 1'b0; d_md_use = 1'b0; reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("mr_nodone_%0d", i), 32'(md_done), 32'd0);
      end
      e_md_start = 1'b1;
      tick(); e_md_start = 1'b0;
      check("mr_first_start", 32'(md_busy), 32'd1);
      check("mr_err_clean",   32'(md_err),  32'd0);
      $display("txn mid_reset: busy=%0b cnt=%0d", md_busy, stall_cnt);

      // Saturation of the stall counter
      do_reset();
      d_load_use = 1'b1;
      force dut.stall_cnt_reg = 32'hFFFF_FFFD;
      #1 release dut.stall_cnt_reg;
      #1;
      check("sat_preset", stall_cnt, 32'hFFFF_FFFD);
      tick();
      check("sat_fe", stall_cnt, 32'hFFFF_FFFE);
      tick();
      check("sat_ff", stall_cnt, 32'hFFFF_FFFF);
      tick();
      check("sat_hold1", stall_cnt, 32'hFFFF_FFFF);
      tick();
      check("sat_hold2", stall_cnt, 32'hFFFF_FFFF);
      d_load_use = 1'b0;
      $display("txn saturate: stall_cnt=%0h", stall_cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL take parameter MULT_CYCLES, default 5; busy cycles for mult/multu.
REQ-002 SHALL take parameter DIV_CYCLES, default 10; busy cycles for div/divu; legal range for both parameters is 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port e_md_start  input  1  E-stage instruction is a valid mult/multu/div/divu.
REQ-006 SHALL have port e_md_is_div  input  1  qualifies e_md_start: 1 = div/divu, 0 = mult/multu.
REQ-007 SHALL have port d_md_use  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have port d_load_use  input  1  decode-stage load-use hazard detected.
REQ-009 SHALL have port md_busy  output  1  multiply/divide unit occupied.
REQ-010 SHALL have port md_done  output  1  one-cycle pulse: HI/LO result valid.
REQ-011 SHALL have port pc_en  output  1  PC write enable.
REQ-012 SHALL have port fd_en  output  1  F/D pipeline register enable.
REQ-013 SHALL have port de_flush  output  1  clear D/E register to a bubble.
REQ-014 SHALL have port md_err  output  1  sticky: start seen while busy.
REQ-015 SHALL have port stall_cnt  output  32  saturating count of stalled cycles.

Function
REQ-016 SHALL implement two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-017 In IDLE with e_md_start=1, SHALL load cnt with DIV_CYCLES if e_md_is_div=1, else MULT_CYCLES, and enter BUSY at the next edge.
REQ-018 In BUSY, SHALL decrement cnt by 1 each cycle; when cnt==1, SHALL enter IDLE at the next edge.
REQ-019 md_busy SHALL equal (state==BUSY), so it is high for exactly the loaded latency in cycles.
REQ-020 md_done SHALL be registered and high for exactly the one cycle after the BUSY->IDLE edge.
REQ-021 stall SHALL be internal and combinational: d_load_use OR (d_md_use AND (md_busy OR e_md_start)).
REQ-022 pc_en and fd_en SHALL equal NOT stall; de_flush SHALL equal stall.
REQ-023 e_md_start while in BUSY SHALL NOT reload cnt or extend BUSY, and SHALL set md_err=1 until reset.
REQ-024 When e_md_start=1 coincides with the BUSY->IDLE edge (cnt==1), SHALL be treated as start-while-busy per REQ-023; it is not a back-to-back issue.
REQ-025 stall_cnt SHALL increment by 1 on every edge where stall=1, and SHALL hold at 0xFFFFFFFF with no wrap.
REQ-026 e_md_is_div SHALL be ignored whenever e_md_start=0.

Reset
REQ-027 Asserting reset at any time, including mid-BUSY, SHALL immediately force state=IDLE, cnt=0, md_done=0, md_err=0 and stall_cnt=0.
REQ-028 During reset, outputs SHALL be md_busy=0, md_done=0 and md_err=0; pc_en, fd_en and de_flush SHALL follow the inputs per REQ-021/022 with md_busy=0.
REQ-029 The first start after reset deassertion SHALL be accepted as from IDLE.

Structure
REQ-030 A shared package SHALL hold the state enum {IDLE, BUSY}, the default latencies 5 and 10, and the counter width 4.
REQ-031 The down-counter and done pulse SHALL be one sub-module, md_timer: inputs load and load_val; outputs busy and done.
REQ-032 Stall combine and the performance counter SHALL remain in the top module.

Verification
REQ-033 Mult latency: e_md_start=1, e_md_is_div=0 for 1 cycle -> md_busy high 5 cycles, md_done high in cycle 6, md_err=0.
REQ-034 Div stall: div start, then d_md_use=1 held -> pc_en=0, fd_en=0, de_flush=1 for the start cycle plus 10 busy cycles; stall_cnt=11.
REQ-035 Load-use: d_load_use=1 for 1 cycle while IDLE -> one stalled cycle, stall_cnt=1, md_busy=0.
REQ-036 Illegal restart: second e_md_start at the 3rd busy cycle of a mult -> BUSY still ends after 5 cycles total, md_err=1 and stays 1.
REQ-037 Reset mid-op: reset pulsed at the 4th cycle of a div -> md_busy=0 asynchronously, md_done never pulses, stall_cnt=0.
REQ-038 Saturation: force stall_cnt near 0xFFFFFFFE with d_load_use=1 held -> value stops at 0xFFFFFFFF.
